mdu_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in EX beside the combinational ALU.
- Accepts one MDU op per cycle from EX.
- Holds the result internally for a programmable latency, then commits it to HI/LO.
- Drives a stall request so the hazard unit freezes D when an MDU-dependent instruction meets a busy unit.

---
 rtl/mdu_unit_pkg.sv | 27 ++
 rtl/mdu_core.sv | 62 ++++++
 rtl/mdu_unit.sv | 107 ++++++++++
 tb/tb_mdu_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_unit_pkg.sv
// Shared MDU opcode encoding and opcode-class helpers for the multiply/divide unit.
package mdu_unit_pkg;

  localparam int MDU_OP_W = 4;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_none  = 4'd0,
    MDU_mult  = 4'd1,
    MDU_multu = 4'd2,
    MDU_div   = 4'd3,
    MDU_divu  = 4'd4,
    MDU_madd  = 4'd5,
    MDU_maddu = 4'd6,
    MDU_mthi  = 4'd7,
    MDU_mtlo  = 4'd8
  } mdu_op_e;

  function automatic logic is_arith(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_mult) || (op == MDU_multu) || (op == MDU_div) ||
           (op == MDU_divu) || (op == MDU_madd)  || (op == MDU_maddu);
  endfunction

  function automatic logic is_div(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_div) || (op == MDU_divu);
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational result generator: products, accumulation, quotient/remainder
// with divide-by-zero and signed-overflow special cases.
module mdu_core
  import mdu_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [MDU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [WIDTH-1:0]    hi,
  input  logic [WIDTH-1:0]    lo,
  output logic [WIDTH-1:0]    res_hi,
  output logic [WIDTH-1:0]    res_lo
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Returns {remainder, quotient}; the overflow case saturates to MOST_NEG/0.
  function automatic logic [W2-1:0] div_signed(input logic [WIDTH-1:0] num,
                                               input logic [WIDTH-1:0] den);
    logic signed [WIDTH-1:0] num_s;
    logic signed [WIDTH-1:0] den_s;
    logic signed [WIDTH-1:0] quo_s;
    logic signed [WIDTH-1:0] rem_s;
    num_s = num;
    den_s = den;
    if ((num == MOST_NEG) && (den == '1)) begin
      return {{WIDTH{1'b0}}, MOST_NEG};
    end
    quo_s = num_s / den_s;
    rem_s = num_s % den_s;
    return {rem_s, quo_s};
  endfunction

  function automatic logic [W2-1:0] div_unsigned(input logic [WIDTH-1:0] num,
                                                 input logic [WIDTH-1:0] den);
    return {num % den, num / den};
  endfunction

  logic [W2-1:0] prod_s;
  logic [W2-1:0] prod_u;
  logic          b_zero;

  always_comb begin
    prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    b_zero = (b == '0);
    {res_hi, res_lo} = {hi, lo};
    case (op)
      MDU_mult:  {res_hi, res_lo} = prod_s;
      MDU_multu: {res_hi, res_lo} = prod_u;
      MDU_madd:  {res_hi, res_lo} = {hi, lo} + prod_s;
      MDU_maddu: {res_hi, res_lo} = {hi, lo} + prod_u;
      MDU_div:   if (!b_zero) {res_hi, res_lo} = div_signed(a, b);
      MDU_divu:  if (!b_zero) {res_hi, res_lo} = div_unsigned(a, b);
      default:   {res_hi, res_lo} = {hi, lo};
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit: holds a precomputed result for a fixed
// latency, then commits it to the architectural HI/LO registers.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [MDU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic [WIDTH-1:0]    hi,
  output logic [WIDTH-1:0]    lo,
  output logic                busy,
  output logic                stall_req
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic             commit;
  logic             start;
  logic [WIDTH-1:0] fwd_hi, fwd_lo;
  logic [WIDTH-1:0] core_hi, core_lo;

  // A new op starting on the commit edge must accumulate onto the result
  // being committed, not onto the stale architectural value.
  assign commit = busy_q && (cnt_q == CNT_W'(1));
  assign start  = is_arith(op) && (!busy_q || commit);
  assign fwd_hi = commit ? pend_hi_q : hi_q;
  assign fwd_lo = commit ? pend_lo_q : lo_q;

  mdu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op     (op),
    .a      (a),
    .b      (b),
    .hi     (fwd_hi),
    .lo     (fwd_lo),
    .res_hi (core_hi),
    .res_lo (core_lo)
  );

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;

    if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (commit) begin
        hi_d   = pend_hi_q;
        lo_d   = pend_lo_q;
        busy_d = 1'b0;
      end
    end else if (op == MDU_mthi) begin
      hi_d = a;
    end else if (op == MDU_mtlo) begin
      lo_d = a;
    end

    if (start) begin
      pend_hi_d = core_hi;
      pend_lo_d = core_lo;
      cnt_d     = is_div(op) ? DIV_LOAD : MULT_LOAD;
      busy_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = busy_q;
  assign stall_req = busy_q | is_arith(op);

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed scenarios plus randomized ops
// compared against a 64-bit arithmetic reference model.
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic          clk;
  logic          reset;
  logic [3:0]    op;
  logic [W-1:0]  a, b;
  logic [W-1:0]  hi, lo;
  logic          busy, stall_req;

  int checks;
  int failures;
  logic [W-1:0] m_hi, m_lo;

  mdu_unit #(
    .WIDTH       (W),
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .a         (a),
    .b         (b),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .stall_req (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit integer arithmetic on the architectural {hi,lo}.
  function automatic logic [63:0] ref_res(input logic [3:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic [W-1:0] h,
                                          input logic [W-1:0] l);
    longint          sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    logic [63:0]     acc;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = {32'd0, x};
    uy  = {32'd0, y};
    acc = {h, l};
    case (o)
      MDU_mult:  return 64'(sx * sy);
      MDU_multu: return 64'(ux * uy);
      MDU_madd:  return acc + 64'(sx * sy);
      MDU_maddu: return acc + 64'(ux * uy);
      MDU_div: begin
        if (y == 0) return acc;
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      MDU_divu: begin
        if (y == 0) return acc;
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
      end
      default: return acc;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b0; op = MDU_mult; a = 32'd5; b = 32'd7;
    cycle();
    cycle();
    reset = 1'b1; op = MDU_none;
    #1;
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h want=%h", hi, 32'd0); end
    checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h want=%h", lo, 32'd0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", stall_req); end
    repeat (MC + 1) cycle();
    checks++; if ({busy, hi, lo} !== 65'd0) begin failures++; $display("FAIL reset_op_ignored got=%b/%h/%h want=0/0/0", busy, hi, lo); end
  endtask

  task automatic test_mult();
    op = MDU_mult; a = 32'hFFFF_FFFE; b = 32'd3;
    #1;
    checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL mult_stall_comb got=%b want=1", stall_req); end
    cycle();
    op = MDU_none;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mult_busy_e0 got=%b want=1", busy); end
    for (int e = 1; e < MC; e++) begin
      cycle();
      checks++;
      if (busy !== 1'b1 || hi !== 32'd0 || lo !== 32'd0) begin
        failures++; $display("FAIL mult_hold_e%0d got=%b/%h/%h want=1/0/0", e, busy, hi, lo);
      end
    end
    cycle();
    checks++;
    if (busy !== 1'b0 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      failures++; $display("FAIL mult_commit got=%b/%h/%h want=0/ffffffff/fffffffa", busy, hi, lo);
    end
  endtask

  task automatic test_madd();
    op = MDU_mtlo; a = 32'd5;
    cycle();
    checks++; if (lo !== 32'd5) begin failures++; $display("FAIL mtlo got=%h want=5", lo); end
    op = MDU_mthi; a = 32'd1;
    cycle();
    checks++; if (hi !== 32'd1) begin failures++; $display("FAIL mthi got=%h want=1", hi); end
    op = MDU_maddu; a = 32'hFFFF_FFFF; b = 32'd2;
    cycle();
    op = MDU_none;
    repeat (MC - 1) cycle();
    checks++;
    if (busy !== 1'b1 || hi !== 32'd1 || lo !== 32'd5) begin
      failures++; $display("FAIL maddu_hold got=%b/%h/%h want=1/1/5", busy, hi, lo);
    end
    cycle();
    checks++;
    if (busy !== 1'b0 || hi !== 32'd3 || lo !== 32'd3) begin
      failures++; $display("FAIL maddu_commit got=%b/%h/%h want=0/3/3", busy, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    op = MDU_divu; a = 32'd7; b = 32'd2;
    cycle();
    op = MDU_none;
    repeat (DC - 1) cycle();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_last_busy got=%b want=1", busy); end
    op = MDU_div; a = 32'hFFFF_FFF9; b = 32'd2;
    cycle();
    op = MDU_none;
    checks++;
    if (busy !== 1'b1 || hi !== 32'd1 || lo !== 32'd3) begin
      failures++; $display("FAIL b2b_divu_commit got=%b/%h/%h want=1/1/3", busy, hi, lo);
    end
    repeat (DC - 1) cycle();
    checks++;
    if (busy !== 1'b1 || hi !== 32'd1 || lo !== 32'd3) begin
      failures++; $display("FAIL b2b_div_hold got=%b/%h/%h want=1/1/3", busy, hi, lo);
    end
    op = MDU_madd; a = 32'hFFFF_FFFF; b = 32'd5;
    cycle();
    op = MDU_none;
    checks++;
    if (busy !== 1'b1 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      failures++; $display("FAIL b2b_div_commit got=%b/%h/%h want=1/ffffffff/fffffffd", busy, hi, lo);
    end
    repeat (MC) cycle();
    checks++;
    if (busy !== 1'b0 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF8) begin
      failures++; $display("FAIL b2b_madd_fwd got=%b/%h/%h want=0/ffffffff/fffffff8", busy, hi, lo);
    end
  endtask

  task automatic test_div_special();
    op = MDU_div; a = 32'h8000_0000; b = 32'hFFFF_FFFF;
    cycle();
    op = MDU_none;
    repeat (DC) cycle();
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'h8000_0000) begin
      failures++; $display("FAIL div_ovf got=%b/%h/%h want=0/0/80000000", busy, hi, lo);
    end
    op = MDU_divu; a = 32'd9; b = 32'd0;
    cycle();
    op = MDU_mthi; a = 32'h1234;
    cycle();
    op = MDU_mult; a = 32'd3; b = 32'd3;
    cycle();
    op = MDU_none;
    checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL busy_stall got=%b want=1", stall_req); end
    repeat (DC - 3) cycle();
    checks++;
    if (busy !== 1'b1 || hi !== 32'd0 || lo !== 32'h8000_0000) begin
      failures++; $display("FAIL divz_hold got=%b/%h/%h want=1/0/80000000", busy, hi, lo);
    end
    cycle();
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'h8000_0000) begin
      failures++; $display("FAIL divz_commit got=%b/%h/%h want=0/0/80000000", busy, hi, lo);
    end
    cycle();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_op_ignored got=%b want=0", busy); end
  endtask

  task automatic test_reset_midop();
    op = MDU_mtlo; a = 32'hAAAA;
    cycle();
    op = MDU_div; a = 32'd100; b = 32'd7;
    cycle();
    op = MDU_none;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++; $display("FAIL midop_reset got=%b/%h/%h want=0/0/0", busy, hi, lo);
    end
    reset = 1'b1;
    repeat (DC + 2) cycle();
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++; $display("FAIL midop_no_late_commit got=%b/%h/%h want=0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_random();
    logic [3:0]  r_op;
    logic [63:0] exp;
    int          n;
    m_hi = 32'd0;
    m_lo = 32'd0;
    for (int i = 0; i < 60; i++) begin
      r_op = 4'($urandom_range(0, 15));
      a    = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      op = r_op;
      if (is_arith(r_op)) begin
        exp = ref_res(r_op, a, b, m_hi, m_lo);
        n   = (r_op == MDU_div || r_op == MDU_divu) ? DC : MC;
        cycle();
        op = MDU_none;
        for (int k = 1; k < n; k++) cycle();
        checks++;
        if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
          failures++; $display("FAIL rnd%0d_hold op=%0d got=%b/%h/%h want=1/%h/%h", i, r_op, busy, hi, lo, m_hi, m_lo);
        end
        cycle();
        {m_hi, m_lo} = exp;
      end else begin
        if (r_op == MDU_mthi) m_hi = a;
        if (r_op == MDU_mtlo) m_lo = a;
        cycle();
        op = MDU_none;
      end
      checks++;
      if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
        failures++; $display("FAIL rnd%0d op=%0d a=%h b=%h got=%b/%h/%h want=0/%h/%h", i, r_op, a, b, busy, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    op = MDU_none;
    a = '0;
    b = '0;
    test_reset();
    test_mult();
    test_madd();
    test_back_to_back();
    test_div_special();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
